data_mem_arbiter: RTL and testbench



---
 rtl/mips_mem_pkg.sv | 17 +
 rtl/rr_arb2.sv | 32 +++
 rtl/data_mem_arbiter.sv | 129 ++++++++++++
 tb/tb_data_mem_arbiter.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, port ids and
// the read-latency counter width.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    localparam int CNT_W = 3;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin chooser. The last-grant flop only moves when the
// arbiter actually accepts a transaction, so a tie goes to the other port.
module rr_arb2
    import mips_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rstb,
    input  logic [1:0] i_req,
    input  logic       i_accept,
    output logic       o_grant
);

    logic r_last;

    always_comb begin
        if (i_req == 2'b11)
            o_grant = ~r_last;
        else if (i_req[1])
            o_grant = PORT_DBG;
        else
            o_grant = PORT_CPU;
    end

    // Reset to the debug port so the CPU wins the first tie.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb)
            r_last <= PORT_DBG;
        else if (i_accept)
            r_last <= o_grant;
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one single-ported data memory between the CPU load/store path and a
// debug/loader port, one transaction at a time, with a req/ack handshake.
module data_mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int AW     = 32,
    parameter int DW     = 32
) (
    input  logic          clk,
    input  logic          rstb,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_ack,
    output logic [DW-1:0] dbg_rdata,
    output logic          mem_wr_en,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wr_data,
    input  logic [DW-1:0] mem_dout
);

    // ISSUE already covers the first read cycle, so WAIT counts RD_LAT-2 more.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((RD_LAT >= 2) ? RD_LAT - 2 : 0);

    state_t           r_state;
    logic             r_win;
    logic             r_we;
    logic [CNT_W-1:0] r_cnt;

    logic          w_any;
    logic          w_accept;
    logic          w_grant;
    logic          w_sel_we;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;
    logic          w_capture;

    assign w_any       = cpu_req | dbg_req;
    assign w_accept    = (r_state == ST_IDLE) && w_any;
    assign w_sel_we    = (w_grant == PORT_DBG) ? dbg_we    : cpu_we;
    assign w_sel_addr  = (w_grant == PORT_DBG) ? dbg_addr  : cpu_addr;
    assign w_sel_wdata = (w_grant == PORT_DBG) ? dbg_wdata : cpu_wdata;
    assign w_capture   = ((r_state == ST_ISSUE) && !r_we && (RD_LAT == 1)) ||
                         ((r_state == ST_WAIT) && (r_cnt == '0));

    assign cpu_stall = cpu_req & ~cpu_ack;

    rr_arb2 u_arb (
        .clk      (clk),
        .rstb     (rstb),
        .i_req    ({dbg_req, cpu_req}),
        .i_accept (w_accept),
        .o_grant  (w_grant)
    );

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state     <= ST_IDLE;
            r_win       <= PORT_CPU;
            r_we        <= 1'b0;
            r_cnt       <= '0;
            cpu_ack     <= 1'b0;
            dbg_ack     <= 1'b0;
            cpu_rdata   <= '0;
            dbg_rdata   <= '0;
            mem_wr_en   <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_win       <= w_grant;
                        r_we        <= w_sel_we;
                        mem_addr    <= w_sel_addr & {{(AW-2){1'b1}}, 2'b00};
                        mem_wr_data <= w_sel_wdata;
                        mem_wr_en   <= w_sel_we;
                        mem_rd_en   <= ~w_sel_we;
                        // Writes complete in the issue cycle, so ack goes out with mem_wr_en.
                        cpu_ack     <= w_sel_we & (w_grant == PORT_CPU);
                        dbg_ack     <= w_sel_we & (w_grant == PORT_DBG);
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE, ST_WAIT: begin
                    if ((r_state == ST_ISSUE) && r_we) begin
                        mem_wr_en <= 1'b0;
                        cpu_ack   <= 1'b0;
                        dbg_ack   <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else if (w_capture) begin
                        mem_rd_en <= 1'b0;
                        if (r_win == PORT_CPU)
                            cpu_rdata <= mem_dout;
                        else
                            dbg_rdata <= mem_dout;
                        cpu_ack <= (r_win == PORT_CPU);
                        dbg_ack <= (r_win == PORT_DBG);
                        r_cnt   <= '0;
                        r_state <= ST_RESP;
                    end else if (r_state == ST_ISSUE) begin
                        r_cnt   <= CNT_LOAD;
                        r_state <= ST_WAIT;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    cpu_ack <= 1'b0;
                    dbg_ack <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with RD_LAT=3.
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        rstb;
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata, mem_dout;
    logic        cpu_ack, cpu_stall, dbg_ack, mem_wr_en, mem_rd_en;
    logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wr_data;

    int checks = 0;
    int errors = 0;

    data_mem_arbiter #(.RD_LAT(3), .AW(32), .DW(32)) dut (
        .clk(clk), .rstb(rstb),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstb = 1'b0; cpu_req = 0; cpu_we = 0; dbg_req = 0; dbg_we = 0;
        cpu_addr = 0; cpu_wdata = 0; dbg_addr = 0; dbg_wdata = 0; mem_dout = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({cpu_ack, dbg_ack, mem_wr_en, mem_rd_en, cpu_stall} !== 5'b0) begin errors++; $display("FAIL reset_ctl: got %b want 00000", {cpu_ack, dbg_ack, mem_wr_en, mem_rd_en, cpu_stall}); end
        checks++; if ({mem_addr, mem_wr_data, cpu_rdata, dbg_rdata} !== 128'h0) begin errors++; $display("FAIL reset_data: got %h want 0", {mem_addr, mem_wr_data, cpu_rdata, dbg_rdata}); end
        @(negedge clk) rstb = 1'b1;
        step();
    endtask

    task automatic test_tie();
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h40; cpu_wdata = 32'h1111_1111;
        dbg_req = 1; dbg_we = 1; dbg_addr = 32'h50; dbg_wdata = 32'h2222_2222;
        step();
        checks++; if ({cpu_ack, dbg_ack} !== 2'b10) begin errors++; $display("FAIL tie1_acks: got %b want 10", {cpu_ack, dbg_ack}); end
        checks++; if (mem_addr !== 32'h40) begin errors++; $display("FAIL tie1_addr: got %h want 00000040", mem_addr); end
        cpu_addr = 32'h60;
        step();
        checks++; if ({cpu_ack, dbg_ack} !== 2'b00) begin errors++; $display("FAIL tie_gap_acks: got %b want 00", {cpu_ack, dbg_ack}); end
        step();
        checks++; if ({cpu_ack, dbg_ack} !== 2'b01) begin errors++; $display("FAIL tie2_acks: got %b want 01", {cpu_ack, dbg_ack}); end
        checks++; if (mem_wr_data !== 32'h2222_2222 || mem_addr !== 32'h50) begin errors++; $display("FAIL tie2_data: got %h/%h want 00000050/22222222", mem_addr, mem_wr_data); end
        cpu_req = 0; dbg_req = 0;
        step();
    endtask

    task automatic test_alternate();
        logic exp_dbg;
        exp_dbg = 1'b0;
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h100;
        dbg_req = 1; dbg_we = 1; dbg_addr = 32'h200;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++; if ({cpu_ack, dbg_ack} !== {~exp_dbg, exp_dbg}) begin errors++; $display("FAIL alt_acks[%0d]: got %b want %b", i, {cpu_ack, dbg_ack}, {~exp_dbg, exp_dbg}); end
            checks++; if (mem_addr !== (exp_dbg ? 32'h200 : 32'h100)) begin errors++; $display("FAIL alt_addr[%0d]: got %h want %h", i, mem_addr, exp_dbg ? 32'h200 : 32'h100); end
            checks++; if (mem_wr_en !== 1'b1) begin errors++; $display("FAIL alt_wren[%0d]: got %b want 1", i, mem_wr_en); end
            if (i == 7) begin cpu_req = 0; dbg_req = 0; end
            exp_dbg = ~exp_dbg;
            step();
            checks++; if ({cpu_ack, dbg_ack, mem_wr_en} !== 3'b000) begin errors++; $display("FAIL alt_idle[%0d]: got %b want 000", i, {cpu_ack, dbg_ack, mem_wr_en}); end
        end
    endtask

    task automatic test_store();
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h0000_0013; cpu_wdata = 32'hDEAD_BEEF;
        #1;
        checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL store_stall_n: got %b want 1", cpu_stall); end
        step();
        checks++; if (mem_wr_en !== 1'b1 || mem_rd_en !== 1'b0) begin errors++; $display("FAIL store_en: got wr=%b rd=%b want wr=1 rd=0", mem_wr_en, mem_rd_en); end
        checks++; if (mem_addr !== 32'h0000_0010) begin errors++; $display("FAIL store_addr: got %h want 00000010", mem_addr); end
        checks++; if (mem_wr_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_data: got %h want deadbeef", mem_wr_data); end
        checks++; if (cpu_ack !== 1'b1 || cpu_stall !== 1'b0) begin errors++; $display("FAIL store_ack: got ack=%b stall=%b want ack=1 stall=0", cpu_ack, cpu_stall); end
        cpu_req = 0;
        step();
        checks++; if ({cpu_ack, mem_wr_en, cpu_stall} !== 3'b000) begin errors++; $display("FAIL store_after: got %b want 000", {cpu_ack, mem_wr_en, cpu_stall}); end
    endtask

    task automatic test_load();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h24; mem_dout = 32'hBAD0_0000;
        step();
        checks++; if (mem_rd_en !== 1'b1 || mem_addr !== 32'h24) begin errors++; $display("FAIL load_n1: got rd=%b addr=%h want rd=1 addr=00000024", mem_rd_en, mem_addr); end
        checks++; if (cpu_ack !== 1'b0 || cpu_stall !== 1'b1) begin errors++; $display("FAIL load_n1_ack: got ack=%b stall=%b want 0/1", cpu_ack, cpu_stall); end
        step();
        checks++; if (mem_rd_en !== 1'b1) begin errors++; $display("FAIL load_n2_rd: got %b want 1", mem_rd_en); end
        step();
        checks++; if (mem_rd_en !== 1'b1 || cpu_ack !== 1'b0) begin errors++; $display("FAIL load_n3: got rd=%b ack=%b want 1/0", mem_rd_en, cpu_ack); end
        mem_dout = 32'h1234_5678;
        step();
        mem_dout = 32'hBAD0_0000;
        checks++; if (cpu_ack !== 1'b1 || mem_rd_en !== 1'b0) begin errors++; $display("FAIL load_n4: got ack=%b rd=%b want 1/0", cpu_ack, mem_rd_en); end
        checks++; if (cpu_rdata !== 32'h1234_5678) begin errors++; $display("FAIL load_rdata: got %h want 12345678", cpu_rdata); end
        cpu_req = 0;
        step();
        checks++; if (cpu_ack !== 1'b0 || cpu_rdata !== 32'h1234_5678) begin errors++; $display("FAIL load_hold: got ack=%b rdata=%h want 0/12345678", cpu_ack, cpu_rdata); end
    endtask

    task automatic test_drop_req();
        dbg_req = 1; dbg_we = 1; dbg_addr = 32'h44; dbg_wdata = 32'h55AA_55AA;
        step();
        dbg_req = 0;
        checks++; if (mem_wr_en !== 1'b1 || dbg_ack !== 1'b1) begin errors++; $display("FAIL drop_n1: got wr=%b ack=%b want 1/1", mem_wr_en, dbg_ack); end
        checks++; if (mem_addr !== 32'h44 || mem_wr_data !== 32'h55AA_55AA) begin errors++; $display("FAIL drop_data: got %h/%h want 00000044/55aa55aa", mem_addr, mem_wr_data); end
        step();
        checks++; if (dbg_ack !== 1'b0 || mem_wr_en !== 1'b0) begin errors++; $display("FAIL drop_n2: got ack=%b wr=%b want 0/0", dbg_ack, mem_wr_en); end
        step();
        checks++; if ({dbg_ack, cpu_ack, mem_wr_en, mem_rd_en} !== 4'b0) begin errors++; $display("FAIL drop_idle: got %b want 0000", {dbg_ack, cpu_ack, mem_wr_en, mem_rd_en}); end
    endtask

    task automatic test_reset_mid_read();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h80; mem_dout = 32'h7777_7777;
        step();
        checks++; if (mem_rd_en !== 1'b1) begin errors++; $display("FAIL rst_pre_rd: got %b want 1", mem_rd_en); end
        step();
        cpu_req = 0;
        rstb = 1'b0;
        #2;
        checks++; if ({cpu_ack, dbg_ack, mem_wr_en, mem_rd_en, cpu_stall} !== 5'b0) begin errors++; $display("FAIL rst_async_ctl: got %b want 00000", {cpu_ack, dbg_ack, mem_wr_en, mem_rd_en, cpu_stall}); end
        checks++; if ({mem_addr, cpu_rdata, dbg_rdata} !== 96'h0) begin errors++; $display("FAIL rst_async_data: got %h want 0", {mem_addr, cpu_rdata, dbg_rdata}); end
        repeat (2) @(posedge clk);
        @(negedge clk) rstb = 1'b1;
        step();
        dbg_req = 1; dbg_we = 0; dbg_addr = 32'h30; mem_dout = 32'hCAFE_F00D;
        repeat (4) step();
        checks++; if (dbg_ack !== 1'b1 || cpu_ack !== 1'b0) begin errors++; $display("FAIL rst_dbg_ack: got dbg=%b cpu=%b want 1/0", dbg_ack, cpu_ack); end
        checks++; if (dbg_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL rst_dbg_rdata: got %h want cafef00d", dbg_rdata); end
        checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL rst_cpu_rdata: got %h want 0", cpu_rdata); end
        dbg_req = 0;
        step();
        checks++; if (dbg_ack !== 1'b0 || dbg_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL rst_dbg_hold: got ack=%b rdata=%h want 0/cafef00d", dbg_ack, dbg_rdata); end
    endtask

    initial begin
        test_reset();
        test_tie();
        test_alternate();
        test_store();
        test_load();
        test_drop_req();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
